// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: pad-side column/row lines and the code/valid output bundle of the keypad scanner
interface keypad_scanner_if;
  logic [3:0] o_col;
  logic [3:0] i_row;
  logic [3:0] o_code;
  logic       o_code_vld;
  modport master (output o_col, o_code, o_code_vld, input i_row);
  modport slave (input o_col, o_code, o_code_vld, output i_row);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces whole frames and strobes one code per press
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input logic             i_clk,
  input logic             i_rst_n,
  keypad_scanner_if.master kp
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  // entry {row,col} holds the code of that key; rows top to bottom, columns left to right
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;
  state_t          state;
  logic [SW-1:0]   slot;
  logic [1:0]      col_idx;
  logic [3:0]      row_m, row_s;
  logic [11:0]     frame;
  logic [3:0]      cand;
  logic [CW-1:0]   cnt;
  logic [15:0]     closed;
  logic [4:0]      n_closed;
  logic [3:0]      hit_code;
  logic            sample, frame_end, none, single;
  // classify the frame formed by columns 0..2 plus the column-3 sample being taken now
  always_comb begin
    sample = slot == SW'(SCAN_DIV - 1);
    frame_end = sample && col_idx == 2'd3;
    closed = ~{row_s, frame};
    n_closed = 5'd0;
    hit_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (closed[i]) begin
        n_closed = n_closed + 5'd1;
        hit_code = KEYMAP[{i[1:0], i[3:2], 2'b00} +: 4];
      end
    end
    none = n_closed == 5'd0;
    single = n_closed == 5'd1;
  end
  // two-flop synchroniser for the asynchronous row pads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_m <= 4'hF;
      row_s <= 4'hF;
    end else begin
      row_m <= kp.i_row;
      row_s <= row_m;
    end
  end
  // slot timing, column rotation and per-column row capture in the last slot cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot <= '0;
      col_idx <= 2'd0;
      kp.o_col <= 4'b1110;
      frame <= 12'hFFF;
    end else begin
      slot <= sample ? '0 : slot + SW'(1);
      if (sample) begin
        col_idx <= col_idx + 2'd1;
        kp.o_col <= {kp.o_col[2:0], kp.o_col[3]};
        frame <= {row_s, frame[11:4]};
      end
    end
  end
  // press/release debounce FSM, stepped once per frame; emits only on entry to HELD from IDLE/PRESS
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cand <= 4'h0;
      cnt <= '0;
      kp.o_code <= 4'h0;
      kp.o_code_vld <= 1'b0;
    end else begin
      kp.o_code_vld <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: if (single) begin
            cand <= hit_code;
            cnt <= CW'(1);
            state <= (DEBOUNCE == 1) ? HELD : PRESS;
            if (DEBOUNCE == 1) begin
              kp.o_code <= hit_code;
              kp.o_code_vld <= 1'b1;
            end
          end
          PRESS: if (!single) state <= IDLE;
          else if (hit_code != cand) begin
            cand <= hit_code;
            cnt <= CW'(1);
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt + CW'(1) >= CW'(DEBOUNCE)) begin
              state <= HELD;
              kp.o_code <= cand;
              kp.o_code_vld <= 1'b1;
            end
          end
          HELD: if (none) begin
            cnt <= CW'(1);
            state <= (DEBOUNCE == 1) ? IDLE : RELEASE;
          end
          RELEASE: if (!none) state <= HELD;
          else if (cnt + CW'(1) >= CW'(DEBOUNCE)) state <= IDLE;
          else cnt <= cnt + CW'(1);
        endcase
      end
    end
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and emits one debounced 4-bit key code per physical key press, qualified by a single-cycle valid strobe.
- Sits directly upstream of the code-lock FSM. o_code/o_code_vld connect straight to its code/code-valid inputs.
- Key map is fixed: rows top to bottom, columns left to right.
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
  - Codes: digits map to their value; A/B/C/D map to 4'hA/4'hB/4'hC/4'hD; * maps to 4'hE; # maps to 4'hF.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven (slot length); must be >= 4.
- DEBOUNCE, 8, consecutive identical frames required to accept a press or a release; must be >= 1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- o_col  output  4  column drive, active-low one-hot (exactly one bit 0 outside reset).
- i_row  input  4  row sense from pads, active-low (0 = key closed on the driven column), asynchronous to i_clk.
- o_code  output  4  code of the accepted key; holds its value until the next accept.
- o_code_vld  output  1  one-cycle strobe, high in the cycle o_code takes a new value.

Behaviour:
- Clock and reset
  - Single clock domain. Reset is asynchronous and active-low.
- Reset values
  - o_col = 4'b1110 (column 0 driven).
  - o_code = 0, o_code_vld = 0.
  - FSM in IDLE; all counters and the row synchroniser cleared to 4'b1111.
- Row synchroniser
  - i_row passes through a 2-flop synchroniser before any use.
- Scan
  - Slot counter runs 0..SCAN_DIV-1.
  - At wrap, o_col rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Synchronised rows are sampled in slot cycle SCAN_DIV-1 only, giving 3+ cycles of settle.
  - The sample for column c goes into frame register bits [4c+3:4c].
- Frame
  - 4 slots = 4*SCAN_DIV cycles.
  - At the end of the column-3 sample, the frame is classified as:
    - NONE: no closed contact.
    - SINGLE(r,c): exactly one closed contact.
    - MULTI: two or more closed contacts.
- FSM (evaluated once per frame end)
  - IDLE
    - SINGLE(k): candidate := k, count := 1. If DEBOUNCE == 1, go to HELD (emit); else go to PRESS.
    - NONE or MULTI: stay in IDLE.
  - PRESS
    - SINGLE(k), k == candidate: count++. When count reaches DEBOUNCE, go to HELD (emit).
    - SINGLE(k), k != candidate: candidate := k, count := 1.
    - NONE or MULTI: go to IDLE.
  - HELD
    - NONE: count := 1, go to RELEASE (if DEBOUNCE == 1, go straight to IDLE).
    - SINGLE or MULTI: stay in HELD. A second key while holding never emits.
  - RELEASE
    - NONE: count++. When count reaches DEBOUNCE, go to IDLE.
    - SINGLE or MULTI: go to HELD (bounce on release, no new emit).
- Emit
  - On entry to HELD from PRESS/IDLE only, in the frame-end cycle + 1: o_code = map(candidate), o_code_vld = 1 for exactly one cycle.
  - Latency from the first qualifying sample to strobe: (DEBOUNCE-1) frames + 1 cycle.
- Auto-repeat
  - None. A held key produces exactly one strobe.
- Reset mid-operation
  - Immediate return to reset values. A partially debounced key is discarded and not emitted after reset release.
  - A key held across reset release is treated as a new press and emits after DEBOUNCE frames.
- Widths and saturation
  - Slot counter: clog2(SCAN_DIV) bits.
  - Debounce counter: clog2(DEBOUNCE+1) bits, saturates at DEBOUNCE.

Test Plan (SCAN_DIV=4, DEBOUNCE=3, frame = 16 cycles):
- Reset, no keys -> o_col cycles 1110/1101/1011/0111, 4 cycles each; o_code_vld never asserts over 20 frames; o_code = 0.
- Hold key "2" (row0,col1) for 10 frames, then release -> exactly one strobe with o_code = 4'h2, 1 cycle after the end of the 3rd full frame containing the key; no further strobes.
- Feed sequence 2,3,2,7, each held 5 frames with 5 release frames between -> four strobes with codes 2,3,2,7 in order; the downstream code-lock FSM opens.
- Bounce: key "5" present in frames 1 and 2, absent in frame 3, then steady -> no strobe until 3 consecutive frames; exactly one strobe with 4'h5.
- Keys "1" and "9" together for 10 frames -> no strobe. Hold "*" then add "#" mid-hold -> only 4'hE strobed. Release with a 1-frame bounce in RELEASE -> no second strobe.
- Deassert i_rst_n asynchronously while in PRESS (2 frames into key "8") -> o_col = 1110 and o_code_vld = 0 immediately. After release, "8" still held -> one strobe 4'h8 after 3 frames.
